mdpram_sched: RTL and testbench



---
 rtl/mdpram_sched_pkg.sv | 17 +
 rtl/mdpram_sched_if.sv | 26 ++
 rtl/mdpram_sched_rd_track.sv | 28 ++
 rtl/mdpram_sched.sv | 127 ++++++++++++
 tb/tb_mdpram_sched.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdpram_sched_pkg.sv
// Shared types and constants for the multiport-RAM scheduler.
//   req_id_t : requester id carried through the read-tracking pipelines
//   rd_trk_t : {valid, id} entry of one read-tracking stage
package mdpram_pkg;
   localparam int MDPRAM_NUM_RD = 2;
   localparam int MDPRAM_NUM_WR = 2;
   // A package cannot see the top's NUM_REQ, so the id is sized for the
   // largest supported requester count (256); the top compares full ids.
   localparam int MDPRAM_ID_W   = 8;

   typedef logic [MDPRAM_ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_trk_t;
endpackage

// File: rtl/mdpram_sched_if.sv
// Requester-side bundle of the scheduler.
//   master : worker lanes (drive requests, receive grants/responses)
//   slave  : mdpram_sched
interface mdpram_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 10,
   parameter int WIDTH   = 17
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ-1:0][AW-1:0]    req_addr;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mdpram_sched_rd_track.sv
// RD_LAT-deep {valid, id} shift pipeline for one RAM read port. The last
// stage lines up with the RAM's read data for the read that loaded stage 0.
//   clk, rst : clock, async active-high reset (drops in-flight reads)
//   ld_i     : {grant, requester id} for this port in the current cycle
//   trk_o    : last stage, qualifies the RAM read data this cycle
module mdpram_rd_track
   import mdpram_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_trk_t ld_i,
   output rd_trk_t trk_o
);
   rd_trk_t [RD_LAT-1:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= ld_i;
         for (int s = 1; s < RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign trk_o = pipe_q[RD_LAT-1];
endmodule

// File: rtl/mdpram_sched.sv
// Round-robin scheduler sharing one 2R/2W read-first RAM among NUM_REQ
// requesters. Grants up to two reads and two writes per cycle, drives the
// RAM ports and routes read data back to the issuing requester RD_LAT
// cycles after the grant.
//   clk, rst        : clock, async active-high reset
//   rif             : requester bundle (valid/we/addr/wdata, ready, rsp)
//   mem_rst_n       : RAM active-low reset (= ~rst)
//   mem_raddr/ren   : RAM read ports, mem_rdata returns RD_LAT later
//   mem_waddr/wen/wdata : RAM write ports
module mdpram_sched
   import mdpram_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  DEPTH   = 1000,
   parameter int  WIDTH   = 17,
   parameter int  RD_LAT  = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   mdpram_sched_if.slave                        rif,
   output logic                                 mem_rst_n,
   output logic [MDPRAM_NUM_RD-1:0][AW-1:0]     mem_raddr,
   output logic [MDPRAM_NUM_RD-1:0]             mem_ren,
   input  logic [MDPRAM_NUM_RD-1:0][WIDTH-1:0]  mem_rdata,
   output logic [MDPRAM_NUM_WR-1:0][AW-1:0]     mem_waddr,
   output logic [MDPRAM_NUM_WR-1:0]             mem_wen,
   output logic [MDPRAM_NUM_WR-1:0][WIDTH-1:0]  mem_wdata
);
   localparam int             IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDW:0]   NREQ    = (IDW+1)'(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ-1);

   logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]         gnt;
   rd_trk_t [MDPRAM_NUM_RD-1:0] trk_ld, trk_out;
   logic [NUM_REQ-1:0]            rsp_v;
   logic [NUM_REQ-1:0][WIDTH-1:0] rsp_d;

   assign mem_rst_n = ~rst;
   // Read ports always enabled out of reset so the RAM pipeline keeps moving;
   // idle ports read address 0 and are masked by the tracking valid.
   assign mem_ren   = {MDPRAM_NUM_RD{~rst}};

   // Round-robin scan from rr_ptr_q: first two reads take read ports 0/1,
   // first write takes write port 0, next write takes port 1 only when its
   // address differs (two writes to one address would collide in the RAM).
   always_comb begin
      logic [1:0]     rd_n, wr_n;
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx, last;
      logic           any;
      gnt       = '0;
      trk_ld    = '0;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wen   = '0;
      mem_wdata = '0;
      rd_n      = '0;
      wr_n      = '0;
      sum       = '0;
      idx       = '0;
      last      = rr_ptr_q;
      any       = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         idx = (sum >= NREQ) ? IDW'(sum - NREQ) : IDW'(sum);
         if (!rst && rif.req_valid[idx]) begin
            if (!rif.req_we[idx]) begin
               if (rd_n != 2'd2) begin
                  gnt[idx]             = 1'b1;
                  mem_raddr[rd_n[0]]   = rif.req_addr[idx];
                  trk_ld[rd_n[0]]      = '{valid: 1'b1, id: req_id_t'(idx)};
                  rd_n                 = rd_n + 2'd1;
                  last                 = idx;
                  any                  = 1'b1;
               end
            end else if (wr_n == 2'd0 ||
                         (wr_n == 2'd1 && rif.req_addr[idx] != mem_waddr[0])) begin
               gnt[idx]           = 1'b1;
               mem_wen[wr_n[0]]   = 1'b1;
               mem_waddr[wr_n[0]] = rif.req_addr[idx];
               mem_wdata[wr_n[0]] = rif.req_wdata[idx];
               wr_n               = wr_n + 2'd1;
               last               = idx;
               any                = 1'b1;
            end
         end
      end
      if (!any)                rr_ptr_d = rr_ptr_q;
      else if (last == LAST_ID) rr_ptr_d = '0;
      else                     rr_ptr_d = last + IDW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

   for (genvar p = 0; p < MDPRAM_NUM_RD; p++) begin : g_trk
      mdpram_rd_track #(.RD_LAT(RD_LAT)) u_trk (
         .clk   (clk),
         .rst   (rst),
         .ld_i  (trk_ld[p]),
         .trk_o (trk_out[p])
      );
   end

   // One requester never holds both read ports, so at most one port hits
   // each requester per cycle.
   always_comb begin
      rsp_v = '0;
      rsp_d = '0;
      for (int p = 0; p < MDPRAM_NUM_RD; p++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (trk_out[p].valid && trk_out[p].id == req_id_t'(i)) begin
               rsp_v[i] = 1'b1;
               rsp_d[i] = mem_rdata[p];
            end
         end
      end
   end

   assign rif.req_ready = gnt;
   assign rif.rsp_valid = rsp_v;
   assign rif.rsp_rdata = rsp_d;
endmodule

// File: tb/tb_mdpram_sched.sv
module tb_mdpram_sched;
   localparam int NR     = 4;
   localparam int DEPTH  = 1000;
   localparam int AW     = 10;
   localparam int WIDTH  = 17;
   localparam int RD_LAT = 3;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic mem_rst_n;
   logic [1:0][AW-1:0]    mem_raddr, mem_waddr;
   logic [1:0]            mem_ren, mem_wen;
   logic [1:0][WIDTH-1:0] mem_rdata, mem_wdata;

   mdpram_sched_if #(.NUM_REQ(NR), .AW(AW), .WIDTH(WIDTH)) rif ();

   mdpram_sched #(.NUM_REQ(NR), .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .rif       (rif),
      .mem_rst_n (mem_rst_n),
      .mem_raddr (mem_raddr),
      .mem_ren   (mem_ren),
      .mem_rdata (mem_rdata),
      .mem_waddr (mem_waddr),
      .mem_wen   (mem_wen),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   // Read-first 2R/2W RAM with RD_LAT-cycle reads.
   logic [WIDTH-1:0] ram [DEPTH] = '{default: '0};
   logic [WIDTH-1:0] rpipe [2][RD_LAT];
   always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         rpipe[p][0] <= ram[mem_raddr[p]];
         for (int s = 1; s < RD_LAT; s++) rpipe[p][s] <= rpipe[p][s-1];
         if (mem_wen[p]) ram[mem_waddr[p]] <= mem_wdata[p];
      end
   end
   always_comb for (int p = 0; p < 2; p++) mem_rdata[p] = rpipe[p][RD_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
   int               m_ptr = 0;
   exp_t             sbq [NR][$];
   logic [NR-1:0]    acc;
   int               mode;
   int               n_cmp = 0;
   int               n_bad = 0;
   exp_t             mon_e;

   // Monitor: compares every presented response against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         n_cmp++;
         if (rif.rsp_valid !== '0 || rif.req_ready !== '0 || mem_ren !== '0 ||
             mem_wen !== '0 || mem_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs cyc %0d: rsp_valid=%b ready=%b ren=%b wen=%b rst_n=%b, all required 0",
                     cyc, rif.rsp_valid, rif.req_ready, mem_ren, mem_wen, mem_rst_n);
         end
      end else begin
         for (int i = 0; i < NR; i++) begin
            while (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
               mon_e = sbq[i].pop_front();
               n_cmp++; n_bad++;
               $display("FAIL missed_rsp[%0d]: no response by cyc %0d, required data %h at cyc %0d",
                        i, cyc, mon_e.data, mon_e.cyc);
            end
            if (rif.rsp_valid[i]) begin
               n_cmp++;
               if (sbq[i].size() == 0) begin
                  n_bad++;
                  $display("FAIL spurious_rsp[%0d] cyc %0d: data %h, no response expected",
                           i, cyc, rif.rsp_rdata[i]);
               end else begin
                  mon_e = sbq[i].pop_front();
                  if (rif.rsp_rdata[i] !== mon_e.data || cyc != mon_e.cyc) begin
                     n_bad++;
                     $display("FAIL rsp[%0d]: got %h at cyc %0d, required %h at cyc %0d",
                              i, rif.rsp_rdata[i], cyc, mon_e.data, mon_e.cyc);
                  end
               end
            end else begin
               n_cmp++;
               if (rif.rsp_rdata[i] !== '0) begin
                  n_bad++;
                  $display("FAIL idle_rdata[%0d] cyc %0d: got %h, required 0", i, cyc, rif.rsp_rdata[i]);
               end
            end
         end
      end
   end

   // Reference grant rule, checks req_ready and queues expected read data.
   task automatic model_step();
      logic [NR-1:0] g;
      logic [AW-1:0] wa0;
      int rd_n, wr_n, last;
      g = '0; rd_n = 0; wr_n = 0; last = -1; wa0 = '0;
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (m_ptr + k) % NR;
         if (rif.req_valid[i]) begin
            if (!rif.req_we[i]) begin
               if (rd_n < 2) begin g[i] = 1'b1; rd_n++; last = i; end
            end else if (wr_n == 0) begin
               g[i] = 1'b1; wr_n = 1; wa0 = rif.req_addr[i]; last = i;
            end else if (wr_n == 1 && rif.req_addr[i] != wa0) begin
               g[i] = 1'b1; wr_n = 2; last = i;
            end
         end
      end
      for (int i = 0; i < NR; i++) begin
         n_cmp++;
         if (rif.req_ready[i] !== g[i]) begin
            n_bad++;
            $display("FAIL ready[%0d] cyc %0d: got %b, required %b", i, cyc, rif.req_ready[i], g[i]);
         end
      end
      // Reads see memory before this cycle's writes.
      for (int i = 0; i < NR; i++)
         if (g[i] && !rif.req_we[i]) sbq[i].push_back('{ref_mem[rif.req_addr[i]], cyc + RD_LAT});
      for (int i = 0; i < NR; i++)
         if (g[i] && rif.req_we[i]) ref_mem[rif.req_addr[i]] = rif.req_wdata[i];
      if (last >= 0) m_ptr = (last + 1) % NR;
      acc = g;
   endtask

   task automatic set_req(int i, bit we, int a, int d);
      rif.req_valid[i] = 1'b1;
      rif.req_we[i]    = we;
      rif.req_addr[i]  = AW'(a);
      rif.req_wdata[i] = WIDTH'(d);
   endtask

   task automatic refill();
      for (int i = 0; i < NR; i++) begin
         if (mode == 2 && (acc[i] || !rif.req_valid[i])) begin
            rif.req_valid[i] = ($urandom_range(0, 4) != 0);
            rif.req_we[i]    = 1'($urandom_range(0, 1));
            rif.req_addr[i]  = AW'($urandom_range(0, 15));
            rif.req_wdata[i] = WIDTH'($urandom);
         end else if (acc[i]) begin
            if (mode == 1) set_req(i, 1'b0, 10 + i, 0);
            else           rif.req_valid[i] = 1'b0;
         end
      end
      acc = '0;
   endtask

   task automatic step();
      @(negedge clk);
      if (!rst) model_step();
      @(posedge clk);
      #1;
      refill();
   endtask

   task automatic run_until_idle(int max);
      for (int n = 0; n < max && rif.req_valid != '0; n++) step();
      n_cmp++;
      if (rif.req_valid != '0) begin
         n_bad++;
         $display("FAIL drain_timeout cyc %0d: valid=%b still pending, required all accepted", cyc, rif.req_valid);
      end
   endtask

   task automatic settle();
      repeat (RD_LAT + 2) step();
   endtask

   initial begin
      rst = 1'b1;
      mode = 0;
      acc = '0;
      rif.req_valid = '0; rif.req_we = '0; rif.req_addr = '0; rif.req_wdata = '0;
      // Requests held through reset must not be granted.
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      run_until_idle(10);
      settle();

      // Two writes, then a read of one of them.
      set_req(0, 1'b1, 5, 'h00AA);
      set_req(1, 1'b1, 6, 'h0155);
      step();
      set_req(2, 1'b0, 5, 0);
      run_until_idle(10);
      settle();

      // Continuous reads from all requesters.
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 10 + i, 0);
      mode = 1;
      repeat (12) step();
      mode = 0;
      run_until_idle(10);
      settle();

      // Same-address write conflict, then read back.
      set_req(1, 1'b1, 7, 'h1111);
      set_req(3, 1'b1, 7, 'h0333);
      run_until_idle(10);
      set_req(0, 1'b0, 7, 0);
      run_until_idle(10);
      settle();

      // Read-first hazard and following read.
      set_req(0, 1'b1, 9, 'h1);
      set_req(1, 1'b0, 9, 0);
      step();
      run_until_idle(10);
      set_req(1, 1'b0, 9, 0);
      run_until_idle(10);
      settle();

      // Back-to-back reads from one requester.
      set_req(0, 1'b1, 1, 'h101); set_req(1, 1'b1, 2, 'h102);
      run_until_idle(10);
      set_req(2, 1'b1, 3, 'h103);
      run_until_idle(10);
      for (int a = 1; a <= 3; a++) begin
         set_req(0, 1'b0, a, 0);
         step();
      end
      settle();

      // Randomized traffic.
      mode = 2;
      repeat (400) step();
      mode = 0;
      run_until_idle(20);
      settle();

      // Reset with reads in flight: they must be dropped.
      set_req(0, 1'b0, 5, 0);
      set_req(1, 1'b0, 6, 0);
      step();
      #1 rst = 1'b1;
      for (int i = 0; i < NR; i++) sbq[i].delete();
      m_ptr = 0;
      acc = '0;
      rif.req_valid = '0;
      set_req(2, 1'b0, 12, 0);
      set_req(3, 1'b0, 13, 0);
      repeat (3) @(posedge clk);
      set_req(0, 1'b0, 10, 0);
      set_req(1, 1'b0, 11, 0);
      #1 rst = 1'b0;
      run_until_idle(10);
      settle();

      for (int i = 0; i < NR; i++) begin
         n_cmp++;
         if (sbq[i].size() != 0) begin
            n_bad++;
            $display("FAIL leftover[%0d]: %0d responses outstanding, required 0", i, sbq[i].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
